keyb_emulator: RTL and testbench
================================

Name: keyb_emulator

Overview:
Keypad-matrix responder, the other end of the keyboardCtrl row-polling interface. It accepts a raw 4-bit matrix key code over a valid/ready handshake. While the scanner drives the matching row on D0/D1, it drives KeyPressed and the column code Q0/Q1, exactly as a physical 4x4 keypad would. It is used to inject keystrokes, for scripted input and for closed-loop verification of the calculator without the physical keypad.

Parameters:
HOLD_CYCLES, 8, number of CLK cycles a key stays pressed after the first row match (>=1)
GAP_CYCLES, 4, idle cycles with no key pressed after release, before the next key is accepted (>=1)
TIMEOUT_CYCLES, 16, max cycles to wait in ARMED for the scanner to select the key's row (>=1)

Ports:
CLK  in  1  system clock
RESET_N  in  1  synchronous, active-low reset
D0  in  1  row select MSB, from the scanner
D1  in  1  row select LSB, from the scanner
KEY_IN  in  4  key to press: [3:2] = row {D0,D1}, [1:0] = column {Q0,Q1}
KEY_VALID  in  1  KEY_IN valid
KEY_READY  out  1  emulator idle; a key is accepted this cycle if KEY_VALID=1
KeyPressed  out  1  key of the currently selected row is pressed, to the scanner
Q0  out  1  column code MSB, to the scanner
Q1  out  1  column code LSB, to the scanner
DONE  out  1  one-cycle pulse when a press completes (entry to GAP from HOLD)
ERR  out  1  one-cycle pulse on row-match timeout
BUSY  out  1  state != IDLE

Behaviour:
- Reset: RESET_N sampled low at a CLK edge -> state IDLE, cnt=0, code_q=0, DONE=0, ERR=0.
- Outputs after reset: KeyPressed=0, Q0=Q1=0, KEY_READY=1, BUSY=0.
- Reset overrides everything, including mid-HOLD. KeyPressed falls after that edge; no DONE or ERR pulse is emitted.
- match = ({D0,D1} == code_q[3:2]).
- KeyPressed is combinational: (state==ARMED || state==HOLD) && match. It responds in the same cycle the scanner changes rows, as a real matrix does.
- {Q0,Q1} = code_q[1:0] when KeyPressed=1, else 2'b00.
- KEY_READY = (state==IDLE). This is a combinational decode of the state register.
- State IDLE: on KEY_VALID && KEY_READY, latch code_q <= KEY_IN, cnt <= 0, go to ARMED.
- State ARMED (waiting for the scanner to select the row):
  - If match: go to HOLD, cnt <= 1. KeyPressed is already high in this cycle.
  - Else if cnt == TIMEOUT_CYCLES-1: ERR=1 for one cycle, go to GAP, cnt <= 0.
  - Else cnt++.
- State HOLD: cnt++ every cycle regardless of match.
  - KeyPressed follows match. If the scanner moves rows, KeyPressed drops and the press time keeps counting.
  - When cnt == HOLD_CYCLES-1: go to GAP, DONE=1 for one cycle, cnt <= 0.
  - Net effect: with a stationary row, KeyPressed is high for exactly HOLD_CYCLES cycles.
  - HOLD_CYCLES=1: go ARMED -> GAP directly on match with DONE=1 (no HOLD cycle).
- State GAP: KeyPressed=0. cnt++; at cnt == GAP_CYCLES-1 go to IDLE.
- KEY_VALID is ignored outside IDLE. No queuing and no overwrite of code_q.
- The emulator never presses two keys at once. Keys are processed strictly one at a time.
- Counter width: clog2 of max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1 bits. There is no wrap in any state, because every count terminates at its limit.
- DONE and ERR are registered and mutually exclusive.
- Key-to-press latency: the cycle after acceptance plus the wait for a row match (0 to 3 scan cycles with a 4-row poller).

Test Plan:
- Reset: hold RESET_N=0 two cycles, toggle D0/D1 -> KeyPressed=0, Q=00, KEY_READY=1, BUSY=0, DONE=ERR=0.
- Closed loop with keyboardCtrl: send KEY_IN=4'b0110 (row 01, col 10) -> KeyPressed high only while {D0,D1}=01, {Q0,Q1}=10, for 8 consecutive cycles. Scanner KeyRead high for that span. DONE pulses once. KEY_READY returns exactly 4 cycles after DONE.
- Timeout: tie {D0,D1}=00, send KEY_IN=4'b1101 -> KeyPressed never asserts. ERR pulses 16 cycles after acceptance. IDLE after 4 further cycles.
- Busy ignore: assert KEY_VALID with 4'b0001 during HOLD of 4'b1010 -> ignored. Q stays 10 and code_q is unchanged. Next key is accepted only after GAP.
- Row moves mid-press: in HOLD, switch D from 10 to 11 for 2 cycles -> KeyPressed=0 and Q=00 for those cycles. DONE still occurs 8 cycles after the first match.
- Reset mid-HOLD: assert RESET_N=0 at HOLD cycle 3 -> KeyPressed=0 after that edge. No DONE. KEY_READY=1 once reset is released.

Source files
------------

// File: rtl/keyb_emulator.sv
// keyb_emulator: keypad-matrix responder for a row-polling scanner.
// Presses one injected key per handshake, holds it, then idles a gap.
module keyb_emulator #(
  parameter int HOLD_CYCLES    = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       D0,
  input  logic       D1,
  input  logic [3:0] KEY_IN,
  input  logic       KEY_VALID,
  output logic       KEY_READY,
  output logic       KeyPressed,
  output logic       Q0,
  output logic       Q1,
  output logic       DONE,
  output logic       ERR,
  output logic       BUSY
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ?
                          HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXC   = (MAX_HG > TIMEOUT_CYCLES) ?
                          MAX_HG : TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HOLD,
    GAP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      code_q, code_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            match;
  logic            pressing;

  assign match    = ({D0, D1} == code_q[3:2]);
  assign pressing = (state_q == ARMED) || (state_q == HOLD);

  assign KeyPressed = pressing && match;
  assign Q0         = KeyPressed && code_q[1];
  assign Q1         = KeyPressed && code_q[0];
  assign KEY_READY  = (state_q == IDLE);
  assign BUSY       = (state_q != IDLE);
  assign DONE       = done_q;
  assign ERR        = err_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (KEY_VALID) begin
          code_d  = KEY_IN;
          cnt_d   = '0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (match) begin
          // A one-cycle hold completes in the matching cycle itself
          if (HOLD_CYCLES == 1) begin
            state_d = GAP;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = HOLD;
            cnt_d   = CW'(1);
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = GAP;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = GAP;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keyb_emulator.sv
// tb_keyb_emulator: directed and random stimulus against a
// timeline model of key presses (acceptance, first hit, gap start).
module tb_keyb_emulator;

  localparam int HOLD = 8;
  localparam int GAPN = 4;
  localparam int TOUT = 16;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       D0 = 1'b0;
  logic       D1 = 1'b0;
  logic [3:0] KEY_IN = 4'h0;
  logic       KEY_VALID = 1'b0;
  logic       KEY_READY;
  logic       KeyPressed;
  logic       Q0;
  logic       Q1;
  logic       DONE;
  logic       ERR;
  logic       BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  keyb_emulator #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAPN),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .D0(D0),
    .D1(D1),
    .KEY_IN(KEY_IN),
    .KEY_VALID(KEY_VALID),
    .KEY_READY(KEY_READY),
    .KeyPressed(KeyPressed),
    .Q0(Q0),
    .Q1(Q1),
    .DONE(DONE),
    .ERR(ERR),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  // Model: one key is a timeline; cycle numbers of its milestones.
  int       cyc = 0;
  bit       m_key = 0;
  bit [3:0] m_code = 0;
  int       m_acc = 0;
  int       m_hit = -1;
  int       m_gap = -1;
  bit       m_ok = 0;

  bit       last_kp = 0;
  logic [1:0] prow = 2'b00;
  int       kp_cnt, done_cnt, err_cnt;
  int       done_at, ready_at;

  task automatic compare();
    bit match, in_gap, e_kp;
    int e_q;
    match  = ({D0, D1} == m_code[3:2]);
    in_gap = m_key && (m_gap >= 0);
    e_kp   = m_key && (m_gap < 0) && match;
    e_q    = e_kp ? int'(m_code[1:0]) : 0;
    chk("KeyPressed", int'(KeyPressed), int'(e_kp));
    chk("Q", int'({Q0, Q1}), e_q);
    chk("KEY_READY", int'(KEY_READY), int'(!m_key));
    chk("BUSY", int'(BUSY), int'(m_key));
    chk("DONE", int'(DONE), int'(in_gap && cyc == m_gap && m_ok));
    chk("ERR", int'(ERR), int'(in_gap && cyc == m_gap && !m_ok));
  endtask

  task automatic model_edge();
    bit match;
    match = ({D0, D1} == m_code[3:2]);
    if (!RESET_N) begin
      m_key = 0;
      m_code = 0;
    end else if (!m_key) begin
      if (KEY_VALID) begin
        m_key  = 1;
        m_code = KEY_IN;
        m_acc  = cyc + 1;
        m_hit  = -1;
        m_gap  = -1;
      end
    end else if (m_gap >= 0) begin
      if (cyc == m_gap + GAPN - 1) m_key = 0;
    end else begin
      if (m_hit < 0 && match) m_hit = cyc;
      if (m_hit >= 0 && cyc - m_hit == HOLD - 1) begin
        m_gap = cyc + 1;
        m_ok  = 1;
      end else if (m_hit < 0 && cyc - m_acc == TOUT - 1) begin
        m_gap = cyc + 1;
        m_ok  = 0;
      end
    end
    cyc++;
  endtask

  task automatic step(input bit rn, input logic [1:0] d,
                      input bit v, input logic [3:0] k);
    @(posedge CLK);
    #1;
    RESET_N   = rn;
    {D0, D1}  = d;
    KEY_VALID = v;
    KEY_IN    = k;
    @(negedge CLK);
    compare();
    last_kp = KeyPressed;
    if (KeyPressed) kp_cnt++;
    if (DONE) begin
      done_cnt++;
      done_at = cyc;
    end
    if (ERR) err_cnt++;
    if (KEY_READY && done_at >= 0 && ready_at < 0) ready_at = cyc;
    model_edge();
  endtask

  // Poller that parks on a row while it sees a key pressed
  function automatic logic [1:0] poll();
    if (!last_kp) prow = prow + 2'b01;
    return prow;
  endfunction

  task automatic clr_stats();
    kp_cnt = 0;
    done_cnt = 0;
    err_cnt = 0;
    done_at = -1;
    ready_at = -1;
  endtask

  initial begin
    int mode;
    logic [1:0] frow;
    clr_stats();

    step(0, 2'b01, 1, 4'h6);
    step(0, 2'b10, 0, 4'h0);
    step(1, 2'b00, 0, 4'h0);

    // Closed loop with a polling scanner
    clr_stats();
    step(1, poll(), 1, 4'b0110);
    for (int i = 0; i < 40; i++) step(1, poll(), 0, 4'h0);
    chk("loop_kp_cycles", kp_cnt, HOLD);
    chk("loop_done_cnt", done_cnt, 1);
    chk("loop_ready_delay", ready_at - done_at, GAPN);

    // Row never selected
    clr_stats();
    step(1, 2'b00, 1, 4'b1101);
    for (int i = 0; i < TOUT + GAPN + 2; i++) step(1, 2'b00, 0, 4'h0);
    chk("tout_kp_cycles", kp_cnt, 0);
    chk("tout_err_cnt", err_cnt, 1);

    // New key offered while busy
    clr_stats();
    step(1, 2'b10, 1, 4'b1010);
    for (int i = 0; i < 20; i++) step(1, 2'b10, 1, 4'b0001);
    for (int i = 0; i < 12; i++) step(1, 2'b00, 0, 4'h0);
    chk("busy_kp_cycles", kp_cnt, HOLD + HOLD);

    // Scanner leaves the row mid-press
    clr_stats();
    step(1, 2'b10, 1, 4'b1011);
    step(1, 2'b10, 0, 4'h0);
    step(1, 2'b11, 0, 4'h0);
    step(1, 2'b11, 0, 4'h0);
    for (int i = 0; i < 14; i++) step(1, 2'b10, 0, 4'h0);
    chk("move_kp_cycles", kp_cnt, HOLD - 2);
    chk("move_done_cnt", done_cnt, 1);

    // Reset during the hold
    clr_stats();
    step(1, 2'b01, 1, 4'b0111);
    for (int i = 0; i < 3; i++) step(1, 2'b01, 0, 4'h0);
    step(0, 2'b01, 0, 4'h0);
    for (int i = 0; i < 14; i++) step(1, 2'b01, 0, 4'h0);
    chk("rst_done_cnt", done_cnt, 0);

    // Random traffic
    mode = 0;
    frow = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] d;
      if (i % 100 == 0) begin
        mode = int'($urandom_range(2, 0));
        frow = 2'($urandom_range(3, 0));
      end
      case (mode)
        0:       d = poll();
        1:       d = frow;
        default: d = 2'($urandom_range(3, 0));
      endcase
      step(($urandom_range(299, 0) != 0), d,
           ($urandom_range(2, 0) == 0), 4'($urandom_range(15, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
